// File: rtl/conv_window_gen_if.sv
// Pixel-stream in / KxK window out handshake bundle for conv_window_gen.
// slave  : the window generator (consumes pixels, produces windows)
// master : the environment feeding pixels and draining windows
interface conv_window_gen_if #(
   parameter int DATA_W = 8,
   parameter int IN_CH  = 1,
   parameter int K      = 3
);
   localparam int PIX_W = DATA_W * IN_CH;

   logic [PIX_W-1:0]                 pix_data;
   logic                             pix_valid;
   logic                             pix_ready;
   logic [K-1:0][K-1:0][PIX_W-1:0]   window;
   logic                             win_valid;
   logic                             win_ready;
   logic                             frame_done;

   modport slave (
      input  pix_data, pix_valid, win_ready,
      output pix_ready, window, win_valid, frame_done
   );

   modport master (
      output pix_data, pix_valid, win_ready,
      input  pix_ready, window, win_valid, frame_done
   );
endinterface

// File: rtl/conv_window_gen.sv
// Raster pixel stream to KxK sliding-window generator. K-1 line buffers hold
// the previous rows; a KxK column shift register assembles the window. One
// window is emitted per position where the kernel fully fits, with full
// backpressure: the whole pipe stalls while a window sits unconsumed.
module conv_window_gen #(
   parameter int DATA_W = 8,
   parameter int IN_CH  = 1,
   parameter int K      = 3,
   parameter int IMG_W  = 5,
   parameter int IMG_H  = 5
) (
   input  logic              clk,
   input  logic              rst,
   conv_window_gen_if.slave  bus
);
   localparam int PIX_W = DATA_W * IN_CH;
   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_FIT  = CW'(K - 1);
   localparam logic [RW-1:0] ROW_FIT  = RW'(K - 1);

   logic [CW-1:0]                   col_q, col_d;
   logic [RW-1:0]                   row_q, row_d;
   logic [K-1:0][K-1:0][PIX_W-1:0]  window_q, window_d;
   logic                            win_valid_q, win_valid_d;
   logic                            frame_done_q, frame_done_d;

   // Row 0 is the oldest buffered line, row K-2 the most recent one.
   logic [PIX_W-1:0]                lb_q [K-1][IMG_W];
   logic [K-1:0][PIX_W-1:0]         col_new;

   logic                            pix_ready;
   logic                            accept;

   assign pix_ready      = !win_valid_q || bus.win_ready;
   assign accept         = bus.pix_valid && pix_ready;

   assign bus.pix_ready  = pix_ready;
   assign bus.window     = window_q;
   assign bus.win_valid  = win_valid_q;
   assign bus.frame_done = frame_done_q;

   // New right-hand window column: buffered rows of this column, top to bottom, then the live pixel.
   always_comb begin
      col_new = '0;
      for (int kr = 0; kr < K - 1; kr++) begin
         col_new[kr] = lb_q[kr][col_q];
      end
      col_new[K-1] = bus.pix_data;
   end

   // Line buffers: the accepted column moves up one row, the live pixel becomes the newest row.
   // Left uninitialised; each entry is written before it can reach a valid window.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int kr = 0; kr < K - 1; kr++) begin
            lb_q[kr][col_q] <= col_new[kr + 1];
         end
      end
   end

   // Next-state: window shift, raster counters, window valid and frame-done pulse.
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      window_d     = window_q;
      win_valid_d  = win_valid_q;
      frame_done_d = 1'b0;

      if (bus.win_ready) begin
         win_valid_d = 1'b0;
      end

      if (accept) begin
         for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K - 1; kc++) begin
               window_d[kr][kc] = window_q[kr][kc + 1];
            end
            window_d[kr][K-1] = col_new[kr];
         end

         // A consume in the same cycle is overridden here, so back-to-back windows have no bubble.
         if (row_q >= ROW_FIT && col_q >= COL_FIT) begin
            win_valid_d = 1'b1;
         end

         if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
               row_d        = '0;
               frame_done_d = 1'b1;
            end else begin
               row_d = row_q + RW'(1);
            end
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         window_q     <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         window_q     <= window_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
      end
   end
endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: a 5x5 instance (A) and a 3x3 instance (B).
// Drivers push expected windows / frame_done cycles; negedge monitors pop and compare.
module tb_conv_window_gen;
   typedef logic [2:0][2:0][7:0] win_t;
   typedef struct {
      win_t win;
      int   ready_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   cyc = 0;

   int   n_chk  = 0;
   int   n_pass = 0;

   exp_t wq0[$];
   exp_t wq1[$];
   int   fq0[$];
   int   fq1[$];
   bit   head_seen [2];
   int   fd_cnt [2];
   int   win_cnt [2];

   conv_window_gen_if #(.DATA_W(8), .IN_CH(1), .K(3)) bus_a ();
   conv_window_gen_if #(.DATA_W(8), .IN_CH(1), .K(3)) bus_b ();

   conv_window_gen #(.DATA_W(8), .IN_CH(1), .K(3), .IMG_W(5), .IMG_H(5)) u_dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   conv_window_gen #(.DATA_W(8), .IN_CH(1), .K(3), .IMG_W(3), .IMG_H(3)) u_dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic mon_step(input int id, input logic r, input logic wv, input logic wr,
                           input logic pr, input logic fd, input win_t win);
      exp_t e;
      int   s;
      int   fexp;
      bit   have;
      if (r) begin
         chk("rst_win_valid", wv, 0);
         chk("rst_frame_done", fd, 0);
         chk("rst_window", win, 0);
         head_seen[id] = 0;
         return;
      end
      if (fd) begin
         fd_cnt[id]++;
         have = (id == 0) ? (fq0.size() > 0) : (fq1.size() > 0);
         if (!have) chk("frame_done_unexpected", 1, 0);
         else begin
            fexp = (id == 0) ? fq0.pop_front() : fq1.pop_front();
            chk("frame_done_cycle", cyc, fexp);
         end
      end
      if (wv) begin
         have = (id == 0) ? (wq0.size() > 0) : (wq1.size() > 0);
         if (!have) chk("win_unexpected", 1, 0);
         else begin
            e = (id == 0) ? wq0[0] : wq1[0];
            if (!head_seen[id]) begin
               chk("win_latency", cyc, e.ready_cyc);
               head_seen[id] = 1;
            end
            chk("win_data", win, e.win);
            if (!wr) chk("stall_pix_ready", pr, 0);
            else begin
               s = 0;
               for (int kr = 0; kr < 3; kr++) s += int'(win[kr][0]) - int'(win[kr][2]);
               chk("conv_sum", s, -6);
               if (id == 0) void'(wq0.pop_front());
               else void'(wq1.pop_front());
               head_seen[id] = 0;
               win_cnt[id]++;
            end
         end
      end
   endtask

   always @(negedge clk) mon_step(0, rst_a, bus_a.win_valid, bus_a.win_ready, bus_a.pix_ready,
                                  bus_a.frame_done, bus_a.window);
   always @(negedge clk) mon_step(1, rst_b, bus_b.win_valid, bus_b.win_ready, bus_b.pix_ready,
                                  bus_b.frame_done, bus_b.window);

   task automatic send_pix(input int id, input logic [7:0] p, input int r, input int c,
                           input int w, input int h, input int base);
      bit   acc = 0;
      int   tries = 0;
      int   ac = 0;
      exp_t e;
      if (id == 0) begin bus_a.pix_data = p; bus_a.pix_valid = 1'b1; end
      else begin bus_b.pix_data = p; bus_b.pix_valid = 1'b1; end
      while (!acc && tries < 50) begin
         @(negedge clk);
         acc = (id == 0) ? bus_a.pix_ready : bus_b.pix_ready;
         ac  = cyc;
         @(posedge clk);
         #1;
         tries++;
      end
      if (id == 0) bus_a.pix_valid = 1'b0;
      else bus_b.pix_valid = 1'b0;
      chk("pix_accept", acc, 1);
      if (acc && r >= 2 && c >= 2) begin
         for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++)
               e.win[kr][kc] = 8'(base + (r - 2 + kr) * w + (c - 2 + kc));
         e.ready_cyc = ac + 1;
         if (id == 0) wq0.push_back(e);
         else wq1.push_back(e);
      end
      if (acc && r == h - 1 && c == w - 1) begin
         if (id == 0) fq0.push_back(ac + 1);
         else fq1.push_back(ac + 1);
      end
   endtask

   task automatic frame(input int id, input int w, input int h, input int base,
                        input int stall_at, input bit gaps, input int stop_after);
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            int idx;
            idx = r * w + c + 1;
            if (stop_after == 0 || idx <= stop_after) begin
               if (gaps) begin
                  repeat ($urandom_range(0, 2)) begin
                     @(posedge clk);
                     #1;
                  end
               end
               send_pix(id, 8'(base + idx - 1), r, c, w, h, base);
               if (idx == stall_at) begin
                  fork
                     begin
                        bus_a.win_ready = 1'b0;
                        repeat (4) @(posedge clk);
                        #1 bus_a.win_ready = 1'b1;
                     end
                  join_none
               end
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string nm);
      idle(8);
      chk({nm, "_winq_empty"}, wq0.size() + wq1.size(), 0);
      chk({nm, "_fdq_empty"}, fq0.size() + fq1.size(), 0);
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.pix_data = '0; bus_a.pix_valid = 1'b0; bus_a.win_ready = 1'b1;
      bus_b.pix_data = '0; bus_b.pix_valid = 1'b0; bus_b.win_ready = 1'b1;
      fd_cnt[0] = 0; fd_cnt[1] = 0; win_cnt[0] = 0; win_cnt[1] = 0;
      head_seen[0] = 0; head_seen[1] = 0;
      idle(3);
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);
      chk("post_rst_pix_ready", bus_a.pix_ready, 1);
      chk("post_rst_win_valid", bus_a.win_valid, 0);
      @(posedge clk); #1;

      // T1: plain frame, pixel every cycle
      frame(0, 5, 5, 1, 0, 0, 0);
      drain("t1");

      // T3: consumer stalls 4 cycles on the first window
      frame(0, 5, 5, 1, 13, 0, 0);
      drain("t3");

      // T4: two frames back-to-back
      frame(0, 5, 5, 1, 0, 0, 0);
      frame(0, 5, 5, 101, 0, 0, 0);
      drain("t4");

      // T5: reset mid-frame after pixel 17, then a fresh frame
      frame(0, 5, 5, 1, 0, 0, 17);
      rst_a = 1'b1;
      idle(2);
      rst_a = 1'b0;
      frame(0, 5, 5, 1, 0, 0, 0);
      drain("t5");

      // T6: 3x3 image with random input gaps
      frame(1, 3, 3, 1, 0, 1, 0);
      drain("t6");

      chk("frame_done_count_a", fd_cnt[0], 5);
      chk("frame_done_count_b", fd_cnt[1], 1);
      chk("window_count_a", win_cnt[0], 48);
      chk("window_count_b", win_cnt[1], 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end
endmodule
